// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants: transmitter state encoding, keyboard command/response bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StShift,
        StAck,
        StWaitIdle
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchroniser for the raw PS/2 clock/data lines plus falling-edge detect on each.
// SYNC_STAGES must be at least 2; flops reset to the idle (high) line level.
module ps2_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_raw,
    input  logic data_raw,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fe,
    output logic data_fe
);

    logic [SYNC_STAGES-1:0] clk_ff;
    logic [SYNC_STAGES-1:0] data_ff;
    logic                   clk_prev;
    logic                   data_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_ff    <= '1;
            data_ff   <= '1;
            clk_prev  <= 1'b1;
            data_prev <= 1'b1;
        end else begin
            clk_ff    <= {clk_ff[SYNC_STAGES-2:0], clk_raw};
            data_ff   <= {data_ff[SYNC_STAGES-2:0], data_raw};
            clk_prev  <= clk_sync;
            data_prev <= data_sync;
        end
    end

    assign clk_sync  = clk_ff[SYNC_STAGES-1];
    assign data_sync = data_ff[SYNC_STAGES-1];
    assign clk_fe    = clk_prev & ~clk_sync;
    assign data_fe   = data_prev & ~data_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send inhibit, device-clocked shift-out, ACK check.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out frame once before reporting tx_error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned TimerMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                       INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    // RTS supplies the last clock-low cycle, so INHIBIT itself lasts one cycle less.
    localparam logic [TimerW-1:0] InhibitLoad = TimerW'(INHIBIT_CYCLES - 2);
    localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t     state;
    logic [9:0]        frame;
    logic [3:0]        fe_cnt;
    logic [TimerW-1:0] timer;
    logic              ack_ok;
`ifdef PS2_TX_RETRY_EN
    logic              retried;
`endif

    logic clk_sync;
    logic data_sync;
    logic clk_fe;
    logic unused_data_fe;

    ps2_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .clk_raw   (ps2_clk_in),
        .data_raw  (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fe    (clk_fe),
        .data_fe   (unused_data_fe)
    );

    logic timeout;
    logic frame_end;
    logic frame_ok;

    always_comb begin
        timeout   = (state inside {StShift, StAck, StWaitIdle}) && (timer == '0);
        frame_end = timeout || (state == StWaitIdle && clk_sync && data_sync);
        frame_ok  = !timeout && ack_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            frame       <= '0;
            fe_cnt      <= '0;
            timer       <= '0;
            ack_ok      <= 1'b0;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            rx_inhibit  <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried     <= 1'b0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (frame_end) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                if (frame_ok) begin
                    tx_done    <= 1'b1;
                    tx_ready   <= 1'b1;
                    rx_inhibit <= 1'b0;
                    state      <= StIdle;
`ifdef PS2_TX_RETRY_EN
                end else if (!retried) begin
                    retried    <= 1'b1;
                    ps2_clk_oe <= 1'b1;
                    timer      <= InhibitLoad;
                    state      <= StInhibit;
`endif
                end else begin
                    tx_error   <= 1'b1;
                    tx_ready   <= 1'b1;
                    rx_inhibit <= 1'b0;
                    state      <= StIdle;
                end
            end else begin
                unique case (state)
                    StIdle: begin
                        if (tx_valid) begin
                            frame       <= {1'b1, ps2_odd_parity(tx_byte), tx_byte};
                            ps2_clk_oe  <= 1'b1;
                            ps2_data_oe <= 1'b0;
                            tx_ready    <= 1'b0;
                            rx_inhibit  <= 1'b1;
                            timer       <= InhibitLoad;
                            state       <= StInhibit;
`ifdef PS2_TX_RETRY_EN
                            retried     <= 1'b0;
`endif
                        end
                    end
                    StInhibit: begin
                        if (timer == '0) begin
                            ps2_data_oe <= 1'b1;
                            state       <= StRts;
                        end else begin
                            timer <= timer - TimerW'(1);
                        end
                    end
                    StRts: begin
                        ps2_clk_oe <= 1'b0;
                        fe_cnt     <= '0;
                        ack_ok     <= 1'b0;
                        timer      <= TimeoutLoad;
                        state      <= StShift;
                    end
                    StShift: begin
                        timer <= timer - TimerW'(1);
                        if (clk_fe) begin
                            // frame[9] is the stop bit (1), which releases the line.
                            ps2_data_oe <= ~frame[fe_cnt];
                            fe_cnt      <= fe_cnt + 4'd1;
                            if (fe_cnt == 4'd9) begin
                                state <= StAck;
                            end
                        end
                    end
                    StAck: begin
                        timer <= timer - TimerW'(1);
                        if (clk_fe) begin
                            ack_ok <= ~data_sync;
                            state  <= StWaitIdle;
                        end
                    end
                    StWaitIdle: begin
                        timer <= timer - TimerW'(1);
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a PS/2 keyboard line model; honours PS2_TX_RETRY_EN.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH  = 40;
    localparam int unsigned TO   = 3000;
    localparam int          HALF = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 2;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, rx_inhibit;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .rx_inhibit  (rx_inhibit),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    typedef struct {
        bit         ok;
        bit         chk_bits;
        logic [9:0] bits;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [9:0] obs_bits = '0;
    int         inh_len = 0;
    int         inh_count = 0;
    int         inh_run = 0;
    int         done_count = 0;
    int         pulse_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Result monitor: every done/error pulse is matched against the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (tx_done || tx_error) begin
            pulse_count++;
            if (tx_done) done_count++;
            check("done_error_exclusive", 32'(tx_done & tx_error), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, tx_done, tx_error}, 0);
            end else begin
                e = exp_q.pop_front();
                check("result_kind", {30'd0, tx_done, tx_error}, e.ok ? 32'd2 : 32'd1);
                if (e.chk_bits) check("frame_bits", 32'(obs_bits), 32'(e.bits));
                check("ready_with_result", 32'(tx_ready), 1);
            end
        end
    end

    // Length and count of clock-inhibit (clk_oe high) phases.
    always @(negedge clk) begin
        if (ps2_clk_oe) begin
            inh_run++;
        end else if (inh_run != 0) begin
            inh_len = inh_run;
            inh_count++;
            inh_run = 0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_byte  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_drop", 32'(tx_ready), 0);
        check("rx_inhibit_set", 32'(rx_inhibit), 1);
    endtask

    // Device model: waits for start bit, clocks n_clk bits, optional 11th clock with ACK.
    task automatic dev_frame(input int n_clk, input bit ack);
        logic [9:0] bits = '0;
        int t = 0;
        while (!(ps2_clk_in && !ps2_data_in) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("dev_start_seen", 32'(t < 1000), 1);
        if (t >= 1000) return;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < n_clk && k < 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            bits[k] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        obs_bits = bits;
        if (n_clk > 10) begin
            if (ack) dev_data_low = 1'b1;
            repeat (2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!(tx_ready && exp_q.size() == 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(t < 2000), 1);
    endtask

    initial begin
        int c0, d0, p0, t, n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx_ready", 32'(tx_ready), 1);
        check("reset_tx_done", 32'(tx_done), 0);
        check("reset_tx_error", 32'(tx_error), 0);
        check("reset_rx_inhibit", 32'(rx_inhibit), 0);
        check("reset_clk_oe", 32'(ps2_clk_oe), 0);
        check("reset_data_oe", 32'(ps2_data_oe), 0);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1 -> 10'h3ED
        exp_q.push_back('{ok: 1'b1, chk_bits: 1'b1, bits: 10'h3ED});
        send(PS2_CMD_SET_LEDS);
        dev_frame(11, 1'b1);
        wait_idle("ed_idle_bounded");
        check("inhibit_len", 32'(inh_len), INH);
        check("ed_ready_back", 32'(tx_ready), 1);

        // 0x07: three ones, parity 0 -> 10'h207
        exp_q.push_back('{ok: 1'b1, chk_bits: 1'b1, bits: 10'h207});
        send(8'h07);
        dev_frame(11, 1'b1);
        wait_idle("x07_idle_bounded");

        // 0xFF NACKed: parity 1 -> 10'h3FF, error only after all attempts
        c0 = inh_count;
        d0 = done_count;
        exp_q.push_back('{ok: 1'b0, chk_bits: 1'b1, bits: 10'h3FF});
        send(PS2_CMD_RESET);
        for (int a = 0; a < ATTEMPTS; a++) dev_frame(11, 1'b0);
        wait_idle("nack_idle_bounded");
        check("nack_inhibit_phases", 32'(inh_count - c0), 32'(ATTEMPTS));
        check("nack_no_done", 32'(done_count - d0), 0);

        // 0x00 with silent device: error exactly TO cycles after clock release
        exp_q.push_back('{ok: 1'b0, chk_bits: 1'b0, bits: 10'h000});
        send(8'h00);
        for (int a = 0; a < ATTEMPTS; a++) begin
            t = 0;
            while (!ps2_clk_oe && t < 500) begin @(negedge clk); t++; end
            t = 0;
            while (ps2_clk_oe && t < 500) begin @(negedge clk); t++; end
        end
        n = 0;
        while (!tx_error && n < 2 * TO) begin @(negedge clk); n++; end
        check("timeout_cycles", 32'(n), TO);
        check("timeout_clk_oe", 32'(ps2_clk_oe), 0);
        check("timeout_data_oe", 32'(ps2_data_oe), 0);
        wait_idle("timeout_idle_bounded");

        // 0xF4 aborted by reset after the 4th falling edge
        p0 = pulse_count;
        send(PS2_CMD_ENABLE);
        dev_frame(4, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_inhibit", 32'(rx_inhibit), 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("rst_no_pulse", 32'(pulse_count - p0), 0);

        // 0xED with 0xEE toggled on tx_valid mid-frame: line keeps 0xED, one done
        d0 = done_count;
        exp_q.push_back('{ok: 1'b1, chk_bits: 1'b1, bits: 10'h3ED});
        send(PS2_CMD_SET_LEDS);
        fork
            dev_frame(11, 1'b1);
            begin
                repeat (INH + 150) @(negedge clk);
                tx_byte = PS2_CMD_ECHO;
                for (int i = 0; i < 6; i++) begin
                    tx_valid = (i % 2 == 0);
                    repeat (7) @(negedge clk);
                end
                tx_valid = 1'b0;
            end
        join
        wait_idle("toggle_idle_bounded");
        repeat (20) @(negedge clk);
        check("toggle_single_done", 32'(done_count - d0), 1);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
